// File: rtl/rvx_constants.sv
// Shared RISC-V branch funct3 encodings and 2-bit BHT counter states.
// Counter helper saturates at both ends; no state, no latency.
package rvx_constants;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rvx_core_branch_compare.sv
// Combinational RISC-V branch condition evaluator, zero latency.
// No state and no flow control; unused funct3 codes resolve not-taken.
module rvx_core_branch_compare
  import rvx_constants::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      funct3,
  output logic            cond_taken
);

  logic eq;
  logic lt_u;
  logic lt_s;

  assign eq   = (rs1_data == rs2_data);
  assign lt_u = (rs1_data < rs2_data);
  // Differing signs: the negative operand (MSB set) is the smaller one.
  assign lt_s = (rs1_data[XLEN-1] != rs2_data[XLEN-1]) ? rs1_data[XLEN-1] : lt_u;

  always_comb begin
    cond_taken = 1'b0;
    case (funct3)
      F3_BEQ:  cond_taken = eq;
      F3_BNE:  cond_taken = ~eq;
      F3_BLT:  cond_taken = lt_s;
      F3_BGE:  cond_taken = ~lt_s;
      F3_BLTU: cond_taken = lt_u;
      F3_BGEU: cond_taken = ~lt_u;
      default: cond_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rvx_core_branch_predictor.sv
// Bimodal 2-bit BHT predictor: zero-latency lookup, branch resolve, 1-cycle registered mispredict.
// stall_s1 freezes table/stat updates and forces mispredict_s2 low; optional stats via RVX_BRANCH_STATS_EN.
module rvx_core_branch_predictor
  import rvx_constants::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc_s0,
  output logic            predict_taken_s0,
  input  logic [XLEN-1:0] pc_s1,
  input  logic [XLEN-1:0] rs1_data_s1,
  input  logic [XLEN-1:0] rs2_data_s1,
  input  logic [2:0]      funct3_s1,
  input  logic            branch_s1,
  input  logic            jump_s1,
  input  logic            predicted_taken_s1,
  input  logic            stall_s1,
  output logic            take_branch_s1,
  output logic            mispredict_s2
`ifdef RVX_BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             mispredict_q;
  logic             mispredict_d;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             cond_taken;
  logic             resolve_en;
  logic             upd_en;
  logic             unused_pc_bits;

  assign fetch_idx = fetch_pc_s0[IDX_W+1:2];
  assign upd_idx   = pc_s1[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc_s0[XLEN-1:IDX_W+2], fetch_pc_s0[1:0],
                            pc_s1[XLEN-1:IDX_W+2], pc_s1[1:0]};

  rvx_core_branch_compare #(.XLEN(XLEN)) u_cmp (
    .rs1_data   (rs1_data_s1),
    .rs2_data   (rs2_data_s1),
    .funct3     (funct3_s1),
    .cond_taken (cond_taken)
  );

  assign take_branch_s1   = jump_s1 ? 1'b1 : (branch_s1 & cond_taken);
  // Read straight from the registered table: same-cycle updates are not bypassed.
  assign predict_taken_s0 = bht_q[fetch_idx][1];
  assign mispredict_s2    = mispredict_q;

  assign resolve_en = (branch_s1 | jump_s1) & ~stall_s1;
  // Jumps never train the table, even when branch_s1 is also raised.
  assign upd_en     = branch_s1 & ~jump_s1 & ~stall_s1;

  always_comb begin
    bht_d = bht_q;
    if (upd_en) bht_d[upd_idx] = ctr_next(bht_q[upd_idx], take_branch_s1);
  end

  always_comb begin
    mispredict_d = resolve_en & (take_branch_s1 != predicted_taken_s1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
      mispredict_q <= 1'b0;
    end else begin
      bht_q        <= bht_d;
      mispredict_q <= mispredict_d;
    end
  end

`ifdef RVX_BRANCH_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] branch_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve_en) branch_count_d = branch_count_q + 32'd1;
    if (mispredict_d) mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_rvx_core_branch_predictor.sv
// Bench for rvx_core_branch_predictor: two instances (64 and 4 entries) share stimulus,
// checked every cycle against an integer-counter reference model plus directed literal checks.
module tb_rvx_core_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc_s0, pc_s1, rs1_data_s1, rs2_data_s1;
  logic [2:0]  funct3_s1;
  logic        branch_s1, jump_s1, predicted_taken_s1, stall_s1;
  logic        pt64, tb64, m64, pt4, tb4, m4;
`ifdef RVX_BRANCH_STATS_EN
  logic [31:0] bc64, mc64, bc4, mc4;
`endif

  always #5 clock = ~clock;

  rvx_core_branch_predictor #(.XLEN(32), .BHT_ENTRIES(64)) dut64 (
    .clock(clock), .reset(reset), .fetch_pc_s0(fetch_pc_s0), .predict_taken_s0(pt64),
    .pc_s1(pc_s1), .rs1_data_s1(rs1_data_s1), .rs2_data_s1(rs2_data_s1),
    .funct3_s1(funct3_s1), .branch_s1(branch_s1), .jump_s1(jump_s1),
    .predicted_taken_s1(predicted_taken_s1), .stall_s1(stall_s1),
    .take_branch_s1(tb64), .mispredict_s2(m64)
`ifdef RVX_BRANCH_STATS_EN
    , .branch_count(bc64), .mispredict_count(mc64)
`endif
  );

  rvx_core_branch_predictor #(.XLEN(32), .BHT_ENTRIES(4)) dut4 (
    .clock(clock), .reset(reset), .fetch_pc_s0(fetch_pc_s0), .predict_taken_s0(pt4),
    .pc_s1(pc_s1), .rs1_data_s1(rs1_data_s1), .rs2_data_s1(rs2_data_s1),
    .funct3_s1(funct3_s1), .branch_s1(branch_s1), .jump_s1(jump_s1),
    .predicted_taken_s1(predicted_taken_s1), .stall_s1(stall_s1),
    .take_branch_s1(tb4), .mispredict_s2(m4)
`ifdef RVX_BRANCH_STATS_EN
    , .branch_count(bc4), .mispredict_count(mc4)
`endif
  );

  // Reference model: counters as integers 0..3, predict taken when >= 2.
  int          bht64 [64];
  int          bht4  [4];
  bit          exp_misp;
  int unsigned exp_bc, exp_mc;
  int          n_checks = 0;
  int          n_err    = 0;
  bit          t_now;

  function automatic bit cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit take_of(input bit j, input bit br, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    if (j) return 1'b1;
    if (br) return cond_of(f, a, b);
    return 1'b0;
  endfunction

  function automatic int sat(input int c, input bit up);
    if (up) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht64[i] = 1;
    for (int i = 0; i < 4; i++) bht4[i] = 1;
    exp_misp = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model advances on each rising edge, outputs checked on the falling edge.
  always begin
    @(posedge clock);
    if (!reset) begin
      t_now    = take_of(jump_s1, branch_s1, funct3_s1, rs1_data_s1, rs2_data_s1);
      exp_misp = (branch_s1 || jump_s1) && !stall_s1 && (t_now != predicted_taken_s1);
      if (branch_s1 && !jump_s1 && !stall_s1) begin
        bht64[(pc_s1 / 4) % 64] = sat(bht64[(pc_s1 / 4) % 64], t_now);
        bht4[(pc_s1 / 4) % 4]   = sat(bht4[(pc_s1 / 4) % 4], t_now);
      end
      if ((branch_s1 || jump_s1) && !stall_s1) exp_bc++;
      if (exp_misp) exp_mc++;
    end
    @(negedge clock);
    if (reset) model_reset();
    t_now = take_of(jump_s1, branch_s1, funct3_s1, rs1_data_s1, rs2_data_s1);
    chk("predict64", {31'd0, pt64}, {31'd0, bht64[(fetch_pc_s0 / 4) % 64] >= 2});
    chk("predict4",  {31'd0, pt4},  {31'd0, bht4[(fetch_pc_s0 / 4) % 4] >= 2});
    chk("take64",    {31'd0, tb64}, {31'd0, t_now});
    chk("take4",     {31'd0, tb4},  {31'd0, t_now});
    chk("mispred64", {31'd0, m64},  {31'd0, exp_misp});
    chk("mispred4",  {31'd0, m4},   {31'd0, exp_misp});
`ifdef RVX_BRANCH_STATS_EN
    chk("bcount64", bc64, exp_bc);
    chk("mcount64", mc64, exp_mc);
    chk("bcount4",  bc4,  exp_bc);
    chk("mcount4",  mc4,  exp_mc);
`endif
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input bit br, input bit j, input bit pred, input bit st);
    pc_s1 = pc; rs1_data_s1 = a; rs2_data_s1 = b; funct3_s1 = f;
    branch_s1 = br; jump_s1 = j; predicted_taken_s1 = pred; stall_s1 = st;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 32'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    fetch_pc_s0 = 32'h100;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    #1 chk("lit_post_reset_pred", {31'd0, pt64}, 32'd0);

    // Three taken BEQ at 0x100: 01 -> 10 -> 11 -> 11.
    for (int k = 0; k < 3; k++) begin
      drive(32'h100, 32'd5, 32'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("lit_beq_model", bht64[0], (k == 0) ? 32'd2 : 32'd3);
      chk("lit_beq_pred", {31'd0, pt64}, 32'd1);
      chk("lit_beq_misp", {31'd0, m64}, 32'd1);
    end

    // Signed vs unsigned less-than.
    fetch_pc_s0 = 32'h208;
    drive(32'h208, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("lit_blt_take", {31'd0, tb64}, 32'd1);
    tick();
    chk("lit_blt_misp", {31'd0, m64}, 32'd1);
    drive(32'h208, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("lit_bltu_take", {31'd0, tb64}, 32'd0);
    tick();
    chk("lit_bltu_misp", {31'd0, m64}, 32'd0);
    chk("lit_blt_entry", bht64[2], 32'd1);

    // Jump overrides a not-taken BNE and leaves the table alone.
    fetch_pc_s0 = 32'h30C;
    drive(32'h30C, 32'd7, 32'd7, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk("lit_jump_take", {31'd0, tb64}, 32'd1);
    tick();
    chk("lit_jump_entry", bht64[3], 32'd1);
    chk("lit_jump_pred", {31'd0, pt64}, 32'd0);
    chk("lit_jump_misp", {31'd0, m64}, 32'd0);

    // Stalled mispredict does nothing; released, it updates and flags.
    fetch_pc_s0 = 32'h414;
    drive(32'h414, 32'd9, 32'd9, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lit_stall_misp", {31'd0, m64}, 32'd0);
    chk("lit_stall_pred", {31'd0, pt64}, 32'd0);
    stall_s1 = 1'b0;
    tick();
    chk("lit_unstall_misp", {31'd0, m64}, 32'd1);
    chk("lit_unstall_pred", {31'd0, pt64}, 32'd1);
    chk("lit_unstall_entry", bht64[5], 32'd2);

    // Aliasing in the 4-entry table: 0x10 not-taken drains the entry trained at 0x100.
    fetch_pc_s0 = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h10, 32'd1, 32'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("lit_alias_pred4", {31'd0, pt4}, 32'd0);
    chk("lit_alias_entry4", bht4[0], 32'd0);
    chk("lit_alias_pred64", {31'd0, pt64}, 32'd1);

    // Reset mid-update discards the pending training.
    fetch_pc_s0 = 32'h100;
    drive(32'h100, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1 chk("lit_midreset_pred64", {31'd0, pt64}, 32'd0);
    chk("lit_midreset_pred4", {31'd0, pt4}, 32'd0);
    chk("lit_midreset_misp", {31'd0, m64}, 32'd0);

    // Ten resolved branches, three mispredicted.
    for (int k = 0; k < 10; k++) begin
      drive(32'h20 + 32'(k * 4), 32'd3, 32'd3, 3'd0, 1'b1, 1'b0, (k >= 3), 1'b0);
      tick();
    end
    idle();
`ifdef RVX_BRANCH_STATS_EN
    chk("lit_stats_bc", bc64, 32'd10);
    chk("lit_stats_mc", mc64, 32'd3);
    chk("lit_stats_bc4", bc4, 32'd10);
    chk("lit_stats_mc4", mc4, 32'd3);
`endif

    // Randomized traffic with occasional stalls and resets.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      case (sel)
        0: a = b;
        1: a = b + 32'd1;
        2: a = ~b;
        default: a = $urandom;
      endcase
      fetch_pc_s0 = {22'd0, 8'($urandom), 2'd0} | ($urandom_range(0, 7) == 0 ? $urandom : 32'd0);
      drive({24'd0, 6'($urandom_range(0, 15)), 2'($urandom)}, a, b, 3'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    idle();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
